simd_adder_pipe: RTL

Pipelined, parametrised SIMD lane adder for the Matrix Processing Unit arithmetic datapath. It splits two NUM_BITS operand vectors into independent LANE_BITS lanes, and carries never cross lane boundaries. Each lane computes add, subtract, unsigned-saturating add or signed-saturating add, selected per transaction. The block adds a two-stage valid/ready pipeline and per-lane overflow flags, and replaces the purely combinational adder in streaming matrix paths.

---
 rtl/simd_pkg.sv | 32 +++
 rtl/simd_lane_add.sv | 62 ++++++
 rtl/simd_adder_pipe.sv | 91 +++++++++
 3 files changed

// File: rtl/simd_pkg.sv
// simd_pkg: mode encodings, LANE_BITS legality check and saturation
// constant helpers shared by simd_adder_pipe and simd_lane_add.
package simd_pkg;

   typedef enum logic [1:0] {
      MODE_ADD   = 2'b00,
      MODE_SUB   = 2'b01,
      MODE_ADDUS = 2'b10,
      MODE_ADDSS = 2'b11
   } mode_e;

   // Lane widths the datapath is built and verified for.
   function automatic bit lane_bits_legal(input int unsigned w);
      return (w == 8) || (w == 16) || (w == 32) || (w == 64);
   endfunction

   // Largest unsigned value of a w-bit lane (w = 64 wraps to all ones).
   function automatic logic [63:0] sat_umax(input int unsigned w);
      return (64'd1 << w) - 64'd1;
   endfunction

   // Largest signed value of a w-bit lane: 0111..1.
   function automatic logic [63:0] sat_smax(input int unsigned w);
      return sat_umax(w) >> 1;
   endfunction

   // Smallest signed value of a w-bit lane: 1000..0.
   function automatic logic [63:0] sat_smin(input int unsigned w);
      return 64'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/simd_lane_add.sv
// simd_lane_add: combinational add/sub/saturating-add for one lane.
// Optional feature macro: SIMD_ADDER_SAT_EN builds the saturation logic;
// without it ADDUS behaves as ADD and ADDSS wraps but flags signed overflow.
module simd_lane_add
   import simd_pkg::*;
#(
   parameter int LANE_BITS = 8
) (
   input  logic [LANE_BITS-1:0] a,
   input  logic [LANE_BITS-1:0] b,
   input  mode_e                mode,
   output logic [LANE_BITS-1:0] res,
   output logic                 ovf
);

   logic [LANE_BITS:0] add_ext;
   logic [LANE_BITS:0] sub_ext;
   logic               carry;
   logic               borrow;
   logic               s_ovf;

   assign add_ext = {1'b0, a} + {1'b0, b};
   assign sub_ext = {1'b0, a} - {1'b0, b};
   assign carry   = add_ext[LANE_BITS];
   assign borrow  = sub_ext[LANE_BITS];
   // Signed overflow: operands agree in sign but the sum does not.
   assign s_ovf   = (a[LANE_BITS-1] == b[LANE_BITS-1]) &&
                    (add_ext[LANE_BITS-1] != a[LANE_BITS-1]);

`ifdef SIMD_ADDER_SAT_EN
   localparam logic [LANE_BITS-1:0] UMAX = LANE_BITS'(sat_umax(LANE_BITS));
   localparam logic [LANE_BITS-1:0] SMAX = LANE_BITS'(sat_smax(LANE_BITS));
   localparam logic [LANE_BITS-1:0] SMIN = LANE_BITS'(sat_smin(LANE_BITS));
`endif

   // Select the lane result and overflow flag for the captured mode.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      res = add_ext[LANE_BITS-1:0];
      ovf = carry;
      case (mode)
         MODE_SUB: begin
            res = sub_ext[LANE_BITS-1:0];
            ovf = borrow;
         end
`ifdef SIMD_ADDER_SAT_EN
         MODE_ADDUS: begin
            if (carry) res = UMAX;
         end
         MODE_ADDSS: begin
            ovf = s_ovf;
            // Overflow only happens with equal signs, so a's sign gives the direction.
            if (s_ovf) res = a[LANE_BITS-1] ? SMIN : SMAX;
         end
`else
         MODE_ADDSS: ovf = s_ovf;
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/simd_adder_pipe.sv
// simd_adder_pipe: two-stage valid/ready SIMD lane adder. Operands are split
// into NUM_LANES independent LANE_BITS lanes; no carry crosses a lane.
// Optional feature macro: SIMD_ADDER_SAT_EN (saturating ADDUS/ADDSS modes).
module simd_adder_pipe
   import simd_pkg::*;
#(
   parameter  int NUM_BITS  = 512,
   parameter  int LANE_BITS = 8,
   localparam int NUM_LANES = NUM_BITS / LANE_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NUM_BITS-1:0]  dd,
   input  logic [NUM_BITS-1:0]  aa,
   input  logic [1:0]           mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NUM_BITS-1:0]  sum,
   output logic [NUM_LANES-1:0] lane_ovf
);

   if ((NUM_BITS % LANE_BITS) != 0) begin : g_bad_num_bits
      $error("simd_adder_pipe: NUM_BITS must be a multiple of LANE_BITS");
   end
   if (!lane_bits_legal(LANE_BITS)) begin : g_bad_lane_bits
      $error("simd_adder_pipe: LANE_BITS must be 8, 16, 32 or 64");
   end

   logic                 s1_valid;
   logic [NUM_BITS-1:0]  s1_dd;
   logic [NUM_BITS-1:0]  s1_aa;
   mode_e                s1_mode;
   logic [NUM_BITS-1:0]  lane_res;
   logic [NUM_LANES-1:0] lane_flag;
   logic                 s2_open;
   logic                 accept;

   // S2 can take a beat when empty or draining this cycle.
   assign s2_open  = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_open;
   assign accept   = in_valid && in_ready;

   // S1: capture operands and mode on handshake; empty once the beat moves on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: operand registers are reset too, so a reset leaves no stale data anywhere.
         s1_valid <= 1'b0;
         s1_dd    <= '0;
         s1_aa    <= '0;
         s1_mode  <= MODE_ADD;
      end else if (accept) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         s1_valid <= 1'b1;
         s1_dd    <= dd;
         s1_aa    <= aa;
         s1_mode  <= mode_e'(mode);
      end else if (s2_open) begin
         s1_valid <= 1'b0;
      end
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      simd_lane_add #(
         .LANE_BITS(LANE_BITS)
      ) u_lane (
         .a    (s1_dd[k*LANE_BITS +: LANE_BITS]),
         .b    (s1_aa[k*LANE_BITS +: LANE_BITS]),
         .mode (s1_mode),
         .res  (lane_res[k*LANE_BITS +: LANE_BITS]),
         .ovf  (lane_flag[k])
      );
   end

   // S2: register lane results; hold them stable while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         lane_ovf  <= '0;
      end else if (s2_open) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            sum      <= lane_res;
            lane_ovf <= lane_flag;
         end
      end
   end

endmodule
